// File: rtl/text_renderer.sv
// rtl/text_renderer.sv - 8x8 character-cell text renderer feeding the font ROM, 3-stage pipeline.
// Optional macro TEXT_BLINK_EN: 6-bit frame counter; codes with bit7 set blink every 32 frames.
module text_renderer #(
  parameter int          COLS     = 80,
  parameter int          ROWS     = 60,
  parameter int          ADDR_W   = 13,
  parameter logic [7:0]  FG_COLOR = 8'hFF,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        i_hcount,
  input  logic [9:0]        i_vcount,
  input  logic              i_video_on,
  input  logic              i_hsync_in,
  input  logic              i_vsync_in,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  output logic [7:0]        o_font_char,
  output logic [2:0]        o_font_x,
  output logic [2:0]        o_font_y,
  input  logic              i_font_pixel,
  output logic [7:0]        o_rgb,
  output logic              o_hsync_out,
  output logic              o_vsync_out
);

  localparam int CELLS = COLS * ROWS;

  // Text buffer powers up as spaces; reset deliberately leaves it alone.
  logic [7:0] r_mem [CELLS] = '{default: 8'h20};

  logic [6:0]        w_col, w_row;
  logic              w_in_grid;
  logic [ADDR_W-1:0] w_addr;
  logic              w_pixel;

  logic [ADDR_W-1:0] r_addr_a;
  logic [2:0]        r_cx_a, r_cy_a;
  logic              r_von_a, r_grid_a, r_hs_a, r_vs_a;

  logic [7:0]        r_char_b;
  logic [2:0]        r_cx_b, r_cy_b;
  logic              r_von_b, r_grid_b, r_hs_b, r_vs_b;

  logic [7:0]        r_rgb;
  logic              r_hs_c, r_vs_c;

  assign w_col     = i_hcount[9:3];
  assign w_row     = i_vcount[9:3];
  assign w_in_grid = (int'(w_col) < COLS) && (int'(w_row) < ROWS);
  // Off-grid cells read address 0 so the RAM index always stays in range.
  assign w_addr    = w_in_grid ? ADDR_W'(int'(w_row) * COLS + int'(w_col)) : '0;

  always_ff @(posedge i_clk) begin
    if (i_wr_en && (int'(i_wr_addr) < CELLS))
      r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr_a <= '0;
      r_cx_a   <= '0;
      r_cy_a   <= '0;
      r_von_a  <= 1'b0;
      r_grid_a <= 1'b0;
      r_hs_a   <= 1'b1;
      r_vs_a   <= 1'b1;
      r_char_b <= '0;
      r_cx_b   <= '0;
      r_cy_b   <= '0;
      r_von_b  <= 1'b0;
      r_grid_b <= 1'b0;
      r_hs_b   <= 1'b1;
      r_vs_b   <= 1'b1;
      r_rgb    <= '0;
      r_hs_c   <= 1'b1;
      r_vs_c   <= 1'b1;
    end else begin
      r_addr_a <= w_addr;
      r_cx_a   <= i_hcount[2:0];
      r_cy_a   <= i_vcount[2:0];
      r_von_a  <= i_video_on;
      r_grid_a <= w_in_grid;
      r_hs_a   <= i_hsync_in;
      r_vs_a   <= i_vsync_in;
      r_char_b <= r_mem[r_addr_a];
      r_cx_b   <= r_cx_a;
      r_cy_b   <= r_cy_a;
      r_von_b  <= r_von_a;
      r_grid_b <= r_grid_a;
      r_hs_b   <= r_hs_a;
      r_vs_b   <= r_vs_a;
      if (!r_von_b)
        r_rgb <= 8'h00;
      else if (!r_grid_b)
        r_rgb <= BG_COLOR;
      else
        r_rgb <= w_pixel ? FG_COLOR : BG_COLOR;
      r_hs_c   <= r_hs_b;
      r_vs_c   <= r_vs_b;
    end
  end

`ifdef TEXT_BLINK_EN
  logic [5:0] r_frame;
  logic       r_vs_prev;

  // Frame boundary = falling edge of the stage-A registered vsync.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame   <= '0;
      r_vs_prev <= 1'b1;
    end else begin
      r_vs_prev <= r_vs_a;
      if (r_vs_prev && !r_vs_a)
        r_frame <= r_frame + 6'd1;
    end
  end

  assign o_font_char = {1'b0, r_char_b[6:0]};
  assign w_pixel     = i_font_pixel & ~(r_char_b[7] & r_frame[5]);
`else
  assign o_font_char = r_char_b;
  assign w_pixel     = i_font_pixel;
`endif

  assign o_font_x    = r_cx_b;
  assign o_font_y    = r_cy_b;
  assign o_rgb       = r_rgb;
  assign o_hsync_out = r_hs_c;
  assign o_vsync_out = r_vs_c;

endmodule

// File: tb/tb_text_renderer.sv
// tb/tb_text_renderer.sv - randomized self-checking bench for text_renderer against a cell-level model.
module tb_text_renderer;
  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcount, vcount;
  logic        video_on, hsync_in, vsync_in, wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  font_char;
  logic [2:0]  font_x, font_y;
  logic        font_pixel;
  logic [7:0]  rgb;
  logic        hsync_out, vsync_out;

  text_renderer dut (
    .i_clk(clk), .i_rst(rst), .i_hcount(hcount), .i_vcount(vcount),
    .i_video_on(video_on), .i_hsync_in(hsync_in), .i_vsync_in(vsync_in),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_font_char(font_char), .o_font_x(font_x), .o_font_y(font_y),
    .i_font_pixel(font_pixel), .o_rgb(rgb),
    .o_hsync_out(hsync_out), .o_vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  int mode;

  function automatic logic glyph(input int md, input logic [7:0] c, input logic [2:0] x, input logic [2:0] y);
    case (md)
      0:       return x == 3'd3;
      1:       return c[x] ^ y[0] ^ y[2];
      default: return 1'b1;
    endcase
  endfunction

  always_comb font_pixel = glyph(mode, font_char, font_x, font_y);

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: buffer contents, frame count and per-sample expected outputs.
  logic [7:0] mem_m [4800];
  int  cnt_m;
  int  vs_prev_m;
  int  cyc = 0;
  bit  v_ok [N];
  bit  c_ok [N];
  int  e_rgb [N], e_hs [N], e_vs [N], e_char [N], e_fx [N], e_fy [N];

  task automatic step(input int r, input int h, input int v, input int von,
                      input int hs, input int vs, input int we, input int wa, input int wd);
    int col, row, ch, fc, pix;
    bit grid;
    @(negedge clk);
    if (cyc >= 2 && v_ok[cyc-2]) begin
      if (c_ok[cyc-2]) check("font_char", int'(font_char), e_char[cyc-2]);
      check("font_x", int'(font_x), e_fx[cyc-2]);
      check("font_y", int'(font_y), e_fy[cyc-2]);
    end
    if (cyc >= 3 && v_ok[cyc-3]) begin
      check("rgb", int'(rgb), e_rgb[cyc-3]);
      check("hsync_out", int'(hsync_out), e_hs[cyc-3]);
      check("vsync_out", int'(vsync_out), e_vs[cyc-3]);
    end
    rst      = r[0];
    hcount   = 10'(h);
    vcount   = 10'(v);
    video_on = von[0];
    hsync_in = hs[0];
    vsync_in = vs[0];
    wr_en    = we[0];
    wr_addr  = 13'(wa);
    wr_data  = 8'(wd);
    if (we != 0 && wa < 4800) mem_m[wa] = 8'(wd);
    if (r != 0) begin
      cnt_m = 0;
      vs_prev_m = 1;
      v_ok[cyc] = 0;
      if (cyc >= 1) v_ok[cyc-1] = 0;
      if (cyc >= 2) v_ok[cyc-2] = 0;
    end else begin
      col  = h / 8;
      row  = v / 8;
      grid = (col < 80) && (row < 60);
      ch   = grid ? int'(mem_m[row*80+col]) : 0;
`ifdef TEXT_BLINK_EN
      if (vs_prev_m == 1 && vs == 0) cnt_m = (cnt_m + 1) % 64;
      fc  = ch % 128;
      pix = int'(glyph(mode, 8'(fc), 3'(h % 8), 3'(v % 8)));
      if (ch >= 128 && cnt_m >= 32) pix = 0;
`else
      fc  = ch;
      pix = int'(glyph(mode, 8'(fc), 3'(h % 8), 3'(v % 8)));
`endif
      vs_prev_m   = vs;
      v_ok[cyc]   = 1;
      c_ok[cyc]   = grid;
      e_char[cyc] = fc;
      e_fx[cyc]   = h % 8;
      e_fy[cyc]   = v % 8;
      e_hs[cyc]   = hs;
      e_vs[cyc]   = vs;
      e_rgb[cyc]  = (von == 0) ? 0 : (!grid ? 8'h00 : (pix != 0 ? 8'hFF : 8'h00));
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 1, 0, 0, 0);
  endtask

  // Blank the pipeline before swapping the ROM stub so in-flight pixels don't depend on it.
  task automatic set_mode(input int m);
    idle(3);
    mode = m;
  endtask

  initial begin
    for (int i = 0; i < 4800; i++) mem_m[i] = 8'h20;
    mode = 0;
    cnt_m = 0;
    vs_prev_m = 1;

    for (int i = 0; i < 3; i++)
      step(1, int'($urandom_range(1023)), int'($urandom_range(1023)), int'($urandom_range(1)),
           int'($urandom_range(1)), int'($urandom_range(1)), 0, 0, 0);
    check("reset_rgb", int'(rgb), 0);
    check("reset_hsync", int'(hsync_out), 1);
    check("reset_vsync", int'(vsync_out), 1);
    check("reset_font_char", int'(font_char), 0);
    check("reset_font_x", int'(font_x), 0);
    check("reset_font_y", int'(font_y), 0);

    step(0, 0, 0, 0, 1, 1, 1, 0, 8'h41);
    for (int h = 0; h < 8; h++) step(0, h, 0, 1, 1, 1, 0, 0, 0);

    step(0, 0, 0, 0, 1, 1, 1, 2*80+5, 8'h58);
    step(0, 43, 17, 1, 1, 1, 0, 0, 0);
    idle(2);

    step(0, 0, 0, 0, 1, 1, 1, 4800, 8'h99);
    for (int h = 0; h < 16; h += 8) step(0, h, 0, 1, 1, 1, 0, 0, 0);

    step(0, 56, 0, 1, 1, 1, 0, 0, 0);
    step(0, 56, 0, 1, 1, 1, 1, 7, 8'h37);
    step(0, 56, 0, 1, 1, 1, 0, 0, 0);

    for (int i = 0; i < 8; i++) step(0, 24 + i, 8, i % 2, i % 2, 1, 0, 0, 0);

    set_mode(1);
    for (int i = 0; i < 1500; i++) begin
      int h, v, we, wa;
      h  = ($urandom_range(7) == 0) ? int'($urandom_range(1023)) : int'($urandom_range(639));
      v  = ($urandom_range(7) == 0) ? int'($urandom_range(1023)) : int'($urandom_range(479));
      we = ($urandom_range(2) == 0) ? 1 : 0;
      wa = ($urandom_range(9) == 0) ? int'($urandom_range(8191)) : int'($urandom_range(4799));
      step((i == 700) ? 1 : 0, h, v, int'($urandom_range(3) != 0), int'($urandom_range(1)),
           int'($urandom_range(1)), we, wa, int'($urandom_range(255)));
    end

    set_mode(2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 0, 8'hC1);
    for (int f = 0; f < 70; f++) begin
      step(0, 0, 0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1, 1, 0, 0, 0);
      step(0, 2, 1, 1, 1, 1, 0, 0, 0);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/text_renderer.md
Name: text_renderer

Overview:
- Character-cell text renderer that sits directly upstream of the font ROM in the VGA message path.
- Takes pixel coordinates and sync signals from the VGA timing generator and looks up the character code in an internal, writable text buffer.
- Drives char/x/y to the font ROM, receives the pixel bit back, and outputs registered colour plus delay-matched syncs.
- 8x8 cells; 640x480 gives an 80x60 grid.

Parameters:
- COLS, 80, text columns.
- ROWS, 60, text rows.
- ADDR_W, 13, text buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- FG_COLOR, 8'hFF, RGB332 colour for a set glyph pixel.
- BG_COLOR, 8'h00, RGB332 colour for a clear glyph pixel inside the active area.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous, active-high reset.
- hcount  in  10  current pixel column from the timing generator.
- vcount  in  10  current pixel row from the timing generator.
- video_on  in  1  high inside the active display area.
- hsync_in  in  1  horizontal sync, active low.
- vsync_in  in  1  vertical sync, active low.
- wr_en  in  1  text buffer write strobe.
- wr_addr  in  ADDR_W  buffer address, row*COLS+col.
- wr_data  in  8  character code to write.
- font_char  out  8  character code to the font ROM.
- font_x  out  3  glyph column to the font ROM.
- font_y  out  3  glyph row to the font ROM.
- font_pixel  in  1  glyph bit returned combinationally by the font ROM.
- rgb  out  8  RGB332 pixel colour.
- hsync_out  out  1  hsync delayed to align with rgb.
- vsync_out  out  1  vsync delayed to align with rgb.

Behaviour:
- Buffer:
  - COLS*ROWS x 8 synchronous RAM, read-first.
  - Contents initialised to 8'h20 (space); rst does NOT clear it.
  - Write at the rising edge when wr_en=1 and wr_addr < COLS*ROWS.
  - Writes with wr_addr >= COLS*ROWS are ignored.
  - A write and a read of the same address in the same cycle returns the old data.
- Stage A (edge E):
  - col = hcount[9:3], row = vcount[9:3].
  - Register addr = row*COLS+col, cx = hcount[2:0], cy = vcount[2:0], video_on, hsync_in, vsync_in.
  - Register in_grid = (col < COLS) && (row < ROWS).
- Stage B (edge E+1):
  - Register the RAM read of addr into char_b; delay cx, cy, video_on, in_grid and syncs by one stage.
  - font_char = char_b, font_x = cx_b, font_y = cy_b, all driven directly from stage-B registers. No bit inversion here; the ROM handles MSB-left ordering.
- Stage C (edge E+2):
  - rgb = 0 if !video_on_b.
  - Otherwise rgb = BG_COLOR if !in_grid_b.
  - Otherwise rgb = font_pixel ? FG_COLOR : BG_COLOR.
  - hsync_out and vsync_out are registered from stage B.
- Latency: inputs sampled at edge E appear on rgb/hsync_out/vsync_out right after edge E+2 (3 register stages). Syncs and colour are always mutually aligned.
- Reset (rst=1 at an edge):
  - All pipeline registers cleared; rgb=0, font_char=0, font_x=0, font_y=0.
  - hsync_out=1 and vsync_out=1 (inactive).
  - Outputs are valid again 3 edges after rst deasserts.
  - A reset mid-frame only corrupts the 3 in-flight pixels.
- Wrap-around: no internal counters in the base build; coordinates come solely from the inputs.

Optional Feature:
- Macro: TEXT_BLINK_EN.
- Defined:
  - 6-bit frame counter, reset to 0.
  - Increments once per frame on the registered falling edge of vsync_in (stage A vs previous value); wraps 63 -> 0.
  - Character codes with bit7 set blink: font_char = {1'b0, char_b[6:0]}.
  - The glyph pixel is forced to 0 when counter[5]=1, so the cell shows BG_COLOR for 32 frames and the glyph for 32 frames.
- Undefined: no counter; font_char = char_b unmodified (all 256 codes render normally).

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> rgb=0, hsync_out=1, vsync_out=1, font_char=0.
- Write/render: write 8'h41 to addr 0; stub font ROM with pixel = (font_x==3); sweep hcount 0..7, vcount 0, video_on=1 -> font_char=8'h41 one edge after each sample; rgb=FF only for hcount=3, 00 elsewhere, each 3 edges after input.
- Addressing: write 8'h58 to addr 2*80+5; drive hcount=43, vcount=17 -> font_char=8'h58, font_x=3, font_y=1.
- Blanking/sync alignment: toggle video_on=0 and hsync_in=0 together -> rgb=0 and hsync_out=0 on the same cycle, exactly 3 edges later.
- Boundaries: write with wr_addr=4800 -> buffer unchanged. Same-cycle write and read at addr 7 -> old char rendered.
- TEXT_BLINK_EN: cell holds 8'hC1 with font stub all-ones -> font_char=8'h41; rgb=FF for frames 0..31 and 00 for frames 32..63. Without the macro, font_char=8'hC1 and rgb is always FF.
